// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared size encodings, arbiter states and alignment helper for the system bus.
package sys_bus_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

    // Size 2'b11 falls through to the last arm and is always rejected.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return (size == SIZE_HALF) ? addr[0] : (size == SIZE_WORD) ? |addr : (size != SIZE_BYTE);
    endfunction
endpackage

// File: rtl/sys_bus_rr_pick.sv
// sys_bus_rr_pick: combinational round-robin picker, first requester after last, wrapping.
module sys_bus_rr_pick #(
    parameter int N_PRI = 2,
    parameter int IW = $clog2(N_PRI)
) (
    input  logic [N_PRI-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);
    // Scan farthest-first so the nearest requester after last overwrites the rest.
    always_comb begin
        valid = 1'b0;
        idx = '0;
        for (int k = N_PRI; k >= 1; k--) begin
            if (req[(int'(last) + k) % N_PRI]) begin
                valid = 1'b1;
                idx = IW'((int'(last) + k) % N_PRI);
            end
        end
    end
endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: N-primary to 1-secondary round-robin bus arbiter with
// alignment checking, ready handshake and transaction timeout.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_PRI = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PRI-1:0]            p_rd,
    input  logic [N_PRI-1:0]            p_wr,
    input  logic [N_PRI-1:0][1:0]       p_size,
    input  logic [N_PRI-1:0][WIDTH-1:0] p_addr,
    input  logic [N_PRI-1:0][WIDTH-1:0] p_wdata,
    output logic [N_PRI-1:0]            p_ready,
    output logic                        p_error,
    output logic [WIDTH-1:0]            p_rdata,
    output logic                        s_rd,
    output logic                        s_wr,
    output logic [1:0]                  s_size,
    output logic [WIDTH-1:0]            s_addr,
    output logic [WIDTH-1:0]            s_wdata,
    input  logic                        s_ready,
    input  logic                        s_error,
    input  logic [WIDTH-1:0]            s_rdata
);
    localparam int IW = $clog2(N_PRI);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pick_valid, busy, bad, tmo, fwd, done;

    sys_bus_rr_pick #(.N_PRI(N_PRI)) u_pick (
        .req  (p_rd | p_wr),
        .last (last_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        busy = state_q == BUSY;
        bad = (p_rd[grant_q] & p_wr[grant_q]) | misaligned(p_size[grant_q], p_addr[grant_q][1:0]);
        // cnt_q counts BUSY cycles already spent, so the limit hits in BUSY cycle TIMEOUT.
        tmo = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !s_ready;
        fwd = busy & ~bad;
        done = busy & (bad | s_ready | tmo);
        s_rd = fwd & ~tmo & p_rd[grant_q];
        s_wr = fwd & ~tmo & p_wr[grant_q];
        s_size = fwd ? p_size[grant_q] : '0;
        s_addr = fwd ? p_addr[grant_q] : '0;
        s_wdata = fwd ? p_wdata[grant_q] : '0;
        p_ready = '0;
        p_ready[grant_q] = done;
        p_error = done & (bad | ~s_ready | s_error);
        p_rdata = (fwd & s_ready) ? s_rdata : '0;
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && pick_valid) begin
            state_d = BUSY;
            grant_d = pick_idx;
            last_d = pick_idx;
            cnt_d = '0;
        end
        if (busy) begin
            cnt_d = (s_ready || cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            state_d = done ? DONE : BUSY;
        end
        if (state_q == DONE) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= IW'(N_PRI - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed and randomized transactions checked against a
// transaction-level model of arbitration, alignment and timeout rules.
module tb_sys_bus_arbiter;
    localparam int W = 32, N = 2, TO = 4;

    logic clk = 1'b0, rst;
    logic [N-1:0] p_rd, p_wr, p_ready;
    logic [N-1:0][1:0] p_size;
    logic [N-1:0][W-1:0] p_addr, p_wdata;
    logic p_error, s_rd, s_wr, s_ready, s_error;
    logic [W-1:0] p_rdata, s_addr, s_wdata, s_rdata;
    logic [1:0] s_size;
    int errors = 0, checks = 0, last = N - 1;

    always #5 clk = ~clk;

    sys_bus_arbiter #(.WIDTH(W), .N_PRI(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p_rd(p_rd), .p_wr(p_wr), .p_size(p_size), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ready(p_ready), .p_error(p_error), .p_rdata(p_rdata),
        .s_rd(s_rd), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_error(s_error), .s_rdata(s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic rd, input logic wr, input logic [1:0] sz, input logic [W-1:0] a);
        int bytes;
        bytes = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        return (rd && wr) || sz == 2'd3 || (a % bytes) != 0;
    endfunction

    // One arbitration round from IDLE; lat = BUSY cycles before s_ready (s_ready in BUSY cycle lat+1).
    task automatic run(input int lat, input logic serr, input logic [W-1:0] rdat);
        int win, c;
        bit bad, ok, fwd;
        win = -1;
        for (int k = 1; k <= N && win < 0; k++)
            if (p_rd[(last + k) % N] || p_wr[(last + k) % N]) win = (last + k) % N;
        bad = is_bad(p_rd[win], p_wr[win], p_size[win], p_addr[win]);
        ok = !bad && (lat + 1 <= TO);
        c = bad ? 1 : ok ? lat + 1 : TO;
        @(negedge clk);
        #1;
        chk("idle_ready", 64'(p_ready), 64'd0);
        chk("idle_strobe", 64'({s_rd, s_wr}), 64'd0);
        @(posedge clk);
        for (int k = 1; k <= c; k++) begin
            @(negedge clk);
            s_ready = !bad && (k == lat + 1);
            s_error = serr;
            s_rdata = rdat;
            #1;
            fwd = !bad && !(k == c && !ok);
            chk($sformatf("s_rd_k%0d", k), 64'(s_rd), 64'(fwd && p_rd[win]));
            chk($sformatf("s_wr_k%0d", k), 64'(s_wr), 64'(fwd && p_wr[win]));
            if (k == 1 && !bad) chk("s_addr", 64'(s_addr), 64'(p_addr[win]));
            if (k < c) chk($sformatf("early_ready_k%0d", k), 64'(p_ready), 64'd0);
            else begin
                chk("p_ready", 64'(p_ready), 64'(1 << win));
                chk("p_error", 64'(p_error), 64'(ok ? serr : 1'b1));
                chk("p_rdata", 64'(p_rdata), 64'(ok ? rdat : '0));
            end
            @(posedge clk);
        end
        #1;
        p_rd[win] = 1'b0;
        p_wr[win] = 1'b0;
        last = win;
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        chk("done_ready", 64'(p_ready), 64'd0);
        chk("done_strobe", 64'({s_rd, s_wr}), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int j, input logic rd, input logic wr, input logic [1:0] sz, input logic [W-1:0] a);
        p_rd[j] = rd;
        p_wr[j] = wr;
        p_size[j] = sz;
        p_addr[j] = a;
        p_wdata[j] = a ^ 32'h5A5A_0000;
    endtask

    initial begin
        logic [W-1:0] tmp;
        rst = 1'b1;
        p_rd = '0; p_wr = '0; p_size = '0; p_addr = '0; p_wdata = '0;
        s_ready = 1'b0; s_error = 1'b0; s_rdata = '0;
        #2;
        chk("rst_ready", 64'(p_ready), 64'd0);
        chk("rst_sec", 64'({s_rd, s_wr, s_size, s_addr}), 64'd0);
        chk("rst_err_data", 64'({p_error, p_rdata}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Zero-wait word read by primary 0.
        arm(0, 1'b1, 1'b0, 2'd2, 32'h100);
        run(0, 1'b0, 32'hDEAD_BEEF);
        // Both primaries request continuously: grants must alternate.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < N; j++)
                if (!(p_rd[j] || p_wr[j])) arm(j, 1'b1, 1'b0, 2'd2, 32'h200 + 32'(j * 4));
            run(1, 1'b0, 32'h1000 + 32'(i));
        end
        p_rd = '0;
        p_wr = '0;
        // Misaligned half write, then illegal size, then rd&wr together.
        arm(1, 1'b0, 1'b1, 2'd1, 32'h103);
        run(0, 1'b0, 32'h1234);
        arm(1, 1'b1, 1'b0, 2'd3, 32'h100);
        run(0, 1'b0, 32'h1234);
        arm(0, 1'b1, 1'b1, 2'd0, 32'h101);
        run(0, 1'b0, 32'h1234);
        // Timeout, then s_ready exactly in the timeout cycle, then 3 waits with error.
        arm(0, 1'b1, 1'b0, 2'd2, 32'h300);
        run(99, 1'b0, 32'hCAFE_F00D);
        arm(1, 1'b1, 1'b0, 2'd1, 32'h302);
        run(3, 1'b0, 32'hCAFE_F00D);
        arm(0, 1'b0, 1'b1, 2'd0, 32'h305);
        run(3, 1'b1, 32'hCAFE_F00D);
        // Reset in BUSY cycle 2 abandons the transaction.
        arm(1, 1'b1, 1'b0, 2'd2, 32'h400);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        p_rd = '0;
        p_wr = '0;
        #1;
        chk("midrst_ready", 64'(p_ready), 64'd0);
        chk("midrst_sec", 64'({s_rd, s_wr, s_size, s_addr, s_wdata}), 64'd0);
        chk("midrst_err_data", 64'({p_error, p_rdata}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last = N - 1;
        @(posedge clk);
        #1;
        arm(0, 1'b1, 1'b0, 2'd2, 32'h500);
        arm(1, 1'b1, 1'b0, 2'd2, 32'h504);
        run(0, 1'b0, 32'h0BAD_F00D);
        run(0, 1'b0, 32'h600D_F00D);
        // Randomized traffic; pending primaries keep their request fields.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!(p_rd[j] || p_wr[j]) && $urandom_range(0, 1) == 1) begin
                    tmp = $urandom;
                    if ($urandom_range(0, 3) != 0) tmp = tmp & 32'hFFFF_FFFC;
                    if ($urandom_range(0, 9) == 0) arm(j, 1'b1, 1'b1, 2'($urandom_range(0, 3)), tmp);
                    else if ($urandom_range(0, 1) == 1) arm(j, 1'b1, 1'b0, 2'($urandom_range(0, 3)), tmp);
                    else arm(j, 1'b0, 1'b1, 2'($urandom_range(0, 3)), tmp);
                end
            end
            if (!(|(p_rd | p_wr))) arm(0, 1'b1, 1'b0, 2'd0, 32'($urandom));
            run(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 32'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
